pci_master_initiator: RTL
=========================

# pci_master_initiator

PCI initiator (bus master) that runs single or burst memory read/write transactions of 1–4 data phases against PCI targets on the shared bus. It is the counterpart of the target-side address decode and DEVSEL logic: it drives FRAME#, IRDY#, AD and C/BE#, and samples DEVSEL# and TRDY#. It sits between a local user interface and the PCI pins.

## Interface
Parameters:
- `ABORT_LIMIT`, default 4: DEVSEL wait limit in clocks after the address phase before a master abort.
- `MAX_LEN`, default 4: maximum data phases per transaction; also the depth of the write buffer.

Ports (all PCI-side control signals are active-low and carry the `_n` suffix):
- `clk` in 1: the single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a transaction; accepted only while `busy`=0.
- `rw` in 1: 1 = write, 0 = read; sampled with `start`.
- `addr` in 32: start address; sampled with `start`.
- `len` in 3: number of data phases; sampled with `start`.
- `wr_push` in 1: push `wr_data` into the write buffer; ignored while `busy`=1 or the buffer is full.
- `wr_data` in 32: write word.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on master abort.
- `rd_valid` out 1: one-cycle strobe, one per completed read phase.
- `rd_data` out 32: read word, valid with `rd_valid`.
- `wr_count` out 3: words currently held in the write buffer.
- `ad_out` out 32: AD drive value.
- `ad_oe` out 1: AD output enable.
- `ad_in` in 32: AD bus sampled.
- `cbe_n` out 4: command or byte enables.
- `frame_n` out 1: FRAME#.
- `irdy_n` out 1: IRDY#.
- `devsel_n` in 1: DEVSEL#.
- `trdy_n` in 1: TRDY#.

## Operation
- Reset values: `frame_n`=1, `irdy_n`=1, `cbe_n`=4'hF, `ad_oe`=0, `ad_out`=0, `busy`=0, `done`=0, `error`=0, `rd_valid`=0, `rd_data`=0, `wr_count`=0. Reset also flushes the write buffer.
- Length rules: `len`=0 is treated as 1; `len`>`MAX_LEN` is clamped to `MAX_LEN`.
- Start rule: a write with `wr_count` less than the effective length is rejected. It produces an `error` pulse and no bus activity.
- FSM states: IDLE, ADDR, DATA, TURN.
  - IDLE → ADDR on an accepted `start`. `addr`, `rw` and the effective length are latched.
  - ADDR (1 cycle): `frame_n`=0, `ad_oe`=1, `ad_out`=addr, `cbe_n`=4'b0111 (memory write) or 4'b0110 (memory read). Always → DATA.
  - DATA: `irdy_n`=0, `cbe_n`=4'b0000.
    - Write: `ad_oe`=1, `ad_out`=buffer[idx].
    - Read: `ad_oe`=0.
    - `frame_n`=1 while the current phase is the last one, else 0.
    - A transfer completes at an edge where `irdy_n`=0, `devsel_n`=0 and `trdy_n`=0. On that edge `idx` increments.
    - Read transfers register `ad_in` into `rd_data`.
    - If `trdy_n`=1 the current phase is held with all outputs unchanged (wait state).
    - After the last transfer → TURN.
  - Master abort: if `devsel_n` has not been sampled low within `ABORT_LIMIT` edges after ADDR, go → TURN with the abort flag set.
  - TURN (1 cycle): `frame_n`=1, `irdy_n`=1, `ad_oe`=0, `cbe_n`=4'hF. Pulse `done`, or `error` if the abort flag is set. The write buffer is emptied. Then → IDLE.
- `busy`=1 in ADDR, DATA and TURN.
- `start` while `busy` is ignored, with no queuing.
- Once DEVSEL has been seen low it is not re-checked. A later high on `devsel_n` only stalls the transfer.
- Target STOP# is not supported.
- Reset mid-transaction: all bus outputs are released on the next edge and the FSM returns to IDLE.

## Timing
- Writes:
  - Zero-wait single write: `start` at edge 0, ADDR in cycle 1, DATA in cycle 2, TURN in cycle 3, `done` high in cycle 3.
  - Minimum length is 3 + len cycles from `start` to IDLE.
- Reads:
  - `rd_valid` is high in the cycle after each transfer edge.
  - The last `rd_valid` coincides with the TURN cycle.
- `frame_n` rises in the same cycle in which the final phase begins. `irdy_n` rises exactly one cycle after the final transfer edge.
- Write buffer:
  - FIFO order.
  - A `wr_push` when full (`wr_count`=`MAX_LEN`) is dropped and the count is unchanged.

## Structure
- A shared package `pci_pkg` holds:
  - PCI command constants: `CMD_MEM_READ`=4'b0110, `CMD_MEM_WRITE`=4'b0111.
  - The FSM state typedef.
  - `BE_ALL`=4'b0000.
- The write buffer is one sub-module, `pci_wr_fifo` (depth `MAX_LEN`, width 32, push/pop/count).
- The FSM and datapath live in the top module.

## Test plan
- Single write, `addr`=22, data 32'hDEADBEEF, target with DEVSEL low on the cycle after ADDR and TRDY low at once:
  - ADDR drives 22 with `cbe_n`=0111.
  - DATA drives DEADBEEF with `frame_n`=1.
  - `done` pulses 3 cycles after `start`.
- 4-phase read from `addr`=21, target returns 1, 2, 3, 4 with 2 wait states before phase 3:
  - `rd_valid` fires 4 times with data 1..4.
  - `frame_n` rises only in phase 4.
- No target responds (`devsel_n` stuck at 1), read at `addr`=100:
  - TURN follows after 4 DATA cycles.
  - `error` pulses, `done` stays 0, `rd_valid` never fires.
- `len`=0 write with 1 word buffered → one data phase. `len`=7 → clamped to 4 phases.
- Write with `len`=3 but `wr_count`=1 → immediate `error`, `frame_n` stays 1.
- `rst` asserted in the middle of the DATA phase of a 4-phase write → next cycle `frame_n`=`irdy_n`=1, `ad_oe`=0, `busy`=0, `wr_count`=0.

Source files
------------

// File: rtl/pci_pkg.sv
// pci_pkg: shared PCI command codes, byte-enable constant and initiator FSM states
package pci_pkg;
  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
  localparam logic [3:0] BE_ALL        = 4'b0000;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;
endpackage

// File: rtl/pci_wr_fifo.sv
// pci_wr_fifo: shift-register write buffer, head always at slot 0
module pci_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [2:0]  count
);
  logic [31:0] r_mem [DEPTH];
  logic [2:0]  r_count;
  logic        w_push_ok;
  assign w_push_ok = push && (r_count < 3'(DEPTH));
  assign dout = r_mem[0];
  assign count = r_count;
  // occupancy: flush/reset empty it, pop has priority over push
  always_ff @(posedge clk) begin
    if (rst || flush) r_count <= '0;
    else if (pop && r_count != 0) r_count <= r_count - 3'd1;
    else if (w_push_ok) r_count <= r_count + 3'd1;
  end
  // storage: pop shifts toward the head, push fills the first empty slot
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
    end else if (w_push_ok) begin
      for (int i = 0; i < DEPTH; i++) if (r_count == 3'(i)) r_mem[i] <= din;
    end
  end
endmodule

// File: rtl/pci_master_initiator.sv
// pci_master_initiator: PCI bus master for 1..MAX_LEN phase memory reads/writes
module pci_master_initiator
  import pci_pkg::*;
#(
  parameter int ABORT_LIMIT = 4,
  parameter int MAX_LEN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic        wr_push,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  wr_count,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [31:0] ad_in,
  output logic [3:0]  cbe_n,
  output logic        frame_n,
  output logic        irdy_n,
  input  logic        devsel_n,
  input  logic        trdy_n
);
  localparam int AW = $clog2(ABORT_LIMIT + 1);
  state_t        r_state, w_next;
  logic [31:0]   r_addr, r_rd_data, w_head;
  logic [2:0]    r_len, r_idx, w_len;
  logic [AW-1:0] r_wait;
  logic          r_rw, r_dev, r_abort, r_rej, r_rd_valid;
  logic          w_idle, w_accept, w_reject, w_xfer, w_last, w_abort;
  assign w_idle   = r_state == IDLE;
  assign w_len    = (len == 3'd0) ? 3'd1 : (len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : len;
  assign w_reject = start && w_idle && rw && (wr_count < w_len);
  assign w_accept = start && w_idle && !w_reject;
  assign w_xfer   = (r_state == DATA) && !devsel_n && !trdy_n;
  assign w_last   = r_idx == r_len - 3'd1;
  assign w_abort  = (r_state == DATA) && !r_dev && devsel_n && (r_wait == AW'(ABORT_LIMIT - 1));
  assign busy     = !w_idle;
  assign done     = (r_state == TURN) && !r_abort;
  assign error    = ((r_state == TURN) && r_abort) || r_rej;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  pci_wr_fifo #(.DEPTH(MAX_LEN)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_push && w_idle), .pop(w_xfer && r_rw),
    .flush(r_state == TURN), .din(wr_data), .dout(w_head), .count(wr_count)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and bus drive, held unchanged across wait states
  always_comb begin
    w_next = (r_state == IDLE) ? (w_accept ? ADDR : IDLE) :
             (r_state == ADDR) ? DATA :
             (r_state == DATA) ? (((w_xfer && w_last) || w_abort) ? TURN : DATA) : IDLE;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    ad_oe   = 1'b0;
    ad_out  = '0;
    cbe_n   = 4'hF;
    if (r_state == ADDR) begin
      frame_n = 1'b0;
      ad_oe   = 1'b1;
      ad_out  = r_addr;
      cbe_n   = r_rw ? CMD_MEM_WRITE : CMD_MEM_READ;
    end
    if (r_state == DATA) begin
      frame_n = w_last;
      irdy_n  = 1'b0;
      cbe_n   = BE_ALL;
      ad_oe   = r_rw;
      ad_out  = r_rw ? w_head : '0;
    end
  end
  // transaction context, phase index, DEVSEL watchdog and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_len      <= 3'd1;
      r_idx      <= '0;
      r_wait     <= '0;
      r_dev      <= 1'b0;
      r_abort    <= 1'b0;
      r_rej      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rej      <= w_reject;
      r_rd_valid <= w_xfer && !r_rw;
      if (w_xfer && !r_rw) r_rd_data <= ad_in;
      if (w_accept) begin
        r_addr  <= addr;
        r_rw    <= rw;
        r_len   <= w_len;
        r_idx   <= '0;
        r_wait  <= '0;
        r_dev   <= 1'b0;
        r_abort <= 1'b0;
      end else if (r_state == DATA) begin
        if (w_xfer) r_idx <= r_idx + 3'd1;
        if (!devsel_n) r_dev <= 1'b1;
        else if (!r_dev) r_wait <= r_wait + AW'(1);
        if (w_abort) r_abort <= 1'b1;
      end
    end
  end
endmodule
